hex_keypad_emulator: RTL
========================

Name: hex_keypad_emulator

Overview:
- Behavioural-synthesizable model of the 4x4 Grayhill 072 switch matrix. It is the responder side of the keypad scan interface: it watches the active-low Col drive from the scanner and pulls the matching Row line low while a commanded key is "pressed".
- Used on-chip for self-test and in simulation to stimulate the keypad scanner, including its debouncer.
- Generates realistic press/release contact bounce from an LFSR, and sequences timed press, hold, release and gap phases under a ready/req handshake.

Parameters:
- HOLD_CYCLES, 1000: default contact-closed duration, used when hold_len = 0.
- BOUNCE_CYCLES, 64: length of each bounce phase. A value of 0 disables bounce.
- GAP_CYCLES, 100: released time after the release bounce, before done.
- LFSR_SEED, 16'hACE1: reset value of the bounce LFSR; must be non-zero.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- Col  in  4  scanner column drive, active-low (bit n low = column n driven)
- key_code  in  4  key to press, 0x0–0xF
- hold_len  in  16  hold duration in cycles; 0 selects HOLD_CYCLES
- bounce_en  in  1  1 = emulate bounce, 0 = clean edges
- press_req  in  1  request a key press; accepted when ready = 1
- abort  in  1  synchronous; terminates the current press
- ready  out  1  high in IDLE only
- done  out  1  one-cycle pulse at end of sequence
- key_active  out  1  current contact state (1 = closed)
- Row  out  4  row lines, active-low; 4'b1111 when no contact

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE, LFSR = LFSR_SEED, counters = 0.
  - ready = 1, done = 0, key_active = 0, Row = 4'b1111.
- Key map: key_code is translated to (col, row) in the scanner's ordering.
  - Col0: rows 0..3 = 1, 2, 3, A
  - Col1: 4, 5, 6, B
  - Col2: 7, 8, 9, C
  - Col3: E, 0, F, D
  - Registered as k_col and k_row on acceptance. key_code is ignored at all other times.
- Row output: combinational in Col, gated by registered state.
  - Row[k_row] = 0 iff key_active = 1 and Col[k_col] = 0.
  - All other Row bits are 1.
  - Non-one-hot Col behaves as a physical matrix: the key's column only needs to be low.
- LFSR: 16-bit Galois, mask 16'hB400.
  - Shifts every cycle in every state except reset.
  - bounce_bit = lfsr[0].
- Handshake:
  - A press is accepted on a rising edge where press_req = 1, ready = 1 and abort = 0.
  - key_code, hold_len (0 replaced by HOLD_CYCLES) and bounce_en are latched at that edge.
  - ready falls the next cycle.
  - press_req while not ready is ignored; it is not queued.
- States. Each counter loads at state entry and the state exits after exactly N cycles.
  - IDLE: key_active = 0. Exits on acceptance.
  - P_BOUNCE: BOUNCE_CYCLES cycles, key_active = bounce_bit. Skipped if latched bounce_en = 0 or BOUNCE_CYCLES = 0.
  - HOLD: hold cycles, key_active = 1.
  - R_BOUNCE: BOUNCE_CYCLES cycles, key_active = bounce_bit. Same skip rule as P_BOUNCE.
  - GAP: GAP_CYCLES cycles, key_active = 0. GAP_CYCLES = 0 skips it.
  - DONE: 1 cycle, done = 1, ready = 0. Then IDLE.
- key_active is registered: it changes only on clock edges.
- abort = 1 in any state other than IDLE or DONE:
  - Next cycle: state = GAP with key_active = 0; the full GAP then runs, then DONE.
  - abort in GAP restarts the GAP count.
  - abort in IDLE or DONE has no effect, except that it blocks acceptance.
- Counters are 16 bits wide and count down to 1; there is no wrap-around.
- Col changes at any time never affect sequencing; they only affect Row.
- Reset mid-sequence:
  - Row goes to 1111 immediately (asynchronous).
  - No done is issued.
  - ready = 1 after reset release.

Test Plan:
- Mapping sweep: bounce_en = 0, hold_len = 16. For each key_code 0..F, rotate Col through 1110, 1101, 1011, 0111 during HOLD. Required: Row low only at the mapped bit (e.g. code 5 + Col 1101 -> Row 1101; code E + Col 0111 -> Row 1110; code 5 + Col 1110 -> Row 1111).
- Timing: HOLD_CYCLES = 8, GAP_CYCLES = 4, bounce off, hold_len = 0, accept at edge 0. Required:
  - key_active high for exactly 8 cycles starting after edge 0.
  - key_active low for 4 cycles.
  - done high for exactly 1 cycle, 13 cycles after acceptance.
  - ready high the following cycle.
- Bounce: BOUNCE_CYCLES = 64, bounce_en = 1, seed ACE1. Required:
  - key_active during P_BOUNCE and R_BOUNCE matches a reference Galois-LFSR bit sequence.
  - Steady 1 in HOLD.
  - Scanner debouncer output shows a single clean press and code.
- Handshake: press_req held high across a sequence. Required: exactly one acceptance per ready window; a request while busy produces no second acceptance until after DONE.
- Abort: abort at cycle 3 of HOLD. Required: key_active = 0 next cycle, GAP_CYCLES later done pulses once; abort + press_req together in IDLE -> not accepted.
- Async reset during HOLD with Col = 1101, code 5. Required: Row = 1111 before the next clock edge, ready = 1 after release, no done pulse.

Source files
------------

// File: rtl/hex_keypad_emulator_if.sv
// Keypad scan lines plus press-command handshake between a scanner/driver and the keypad emulator.
// master = scanner/driver side, slave = emulator side.
interface hex_keypad_emulator_if;
  logic [3:0]  Col;
  logic [3:0]  key_code;
  logic [15:0] hold_len;
  logic        bounce_en;
  logic        press_req;
  logic        abort;
  logic        ready;
  logic        done;
  logic        key_active;
  logic [3:0]  Row;

  modport master (output Col, key_code, hold_len, bounce_en, press_req, abort,
                  input  ready, done, key_active, Row);
  modport slave  (input  Col, key_code, hold_len, bounce_en, press_req, abort,
                  output ready, done, key_active, Row);
endinterface

// File: rtl/hex_keypad_emulator.sv
// 4x4 keypad switch-matrix responder: pulls the commanded key's row low while its column is driven.
// Latency: Row is combinational in Col; contact state follows acceptance by one clock edge.
// Backpressure: ready only in IDLE; press_req while busy is dropped, abort jumps to the release gap.
module hex_keypad_emulator #(
  parameter int unsigned HOLD_CYCLES   = 1000,
  parameter int unsigned BOUNCE_CYCLES = 64,
  parameter int unsigned GAP_CYCLES    = 100,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input logic                  clock,
  input logic                  reset,
  hex_keypad_emulator_if.slave kp
);
  typedef enum logic [2:0] {IDLE, P_BOUNCE, HOLD, R_BOUNCE, GAP, DONE} state_t;

  localparam logic [15:0] BOUNCE_LEN = 16'(BOUNCE_CYCLES);
  localparam logic [15:0] GAP_LEN    = 16'(GAP_CYCLES);
  localparam logic [15:0] HOLD_DEF   = 16'(HOLD_CYCLES);
  localparam logic [15:0] LFSR_MASK  = 16'hB400;
  localparam logic        BOUNCE_ON  = (BOUNCE_CYCLES != 0);
  localparam logic        GAP_ON     = (GAP_CYCLES != 0);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [15:0] lfsr, lfsr_nxt;
  logic [15:0] hold_l, hold_sel;
  logic        bounce_l;
  logic [1:0]  k_col, k_row;
  logic [1:0]  map_col, map_row;
  logic        key_active, key_active_nxt;
  logic        accept;
  logic [3:0]  row_drv;

  assign accept   = (state == IDLE) && kp.press_req && !kp.abort;
  assign hold_sel = (kp.hold_len == 16'd0) ? HOLD_DEF : kp.hold_len;
  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);

  // Scanner ordering: {col, row} for each key code.
  always_comb begin
    {map_col, map_row} = 4'b0000;
    case (kp.key_code)
      4'h1: {map_col, map_row} = {2'd0, 2'd0};
      4'h2: {map_col, map_row} = {2'd0, 2'd1};
      4'h3: {map_col, map_row} = {2'd0, 2'd2};
      4'hA: {map_col, map_row} = {2'd0, 2'd3};
      4'h4: {map_col, map_row} = {2'd1, 2'd0};
      4'h5: {map_col, map_row} = {2'd1, 2'd1};
      4'h6: {map_col, map_row} = {2'd1, 2'd2};
      4'hB: {map_col, map_row} = {2'd1, 2'd3};
      4'h7: {map_col, map_row} = {2'd2, 2'd0};
      4'h8: {map_col, map_row} = {2'd2, 2'd1};
      4'h9: {map_col, map_row} = {2'd2, 2'd2};
      4'hC: {map_col, map_row} = {2'd2, 2'd3};
      4'hE: {map_col, map_row} = {2'd3, 2'd0};
      4'h0: {map_col, map_row} = {2'd3, 2'd1};
      4'hF: {map_col, map_row} = {2'd3, 2'd2};
      default: {map_col, map_row} = {2'd3, 2'd3};
    endcase
  end

  // Counters load on state entry; a phase ends when the count reaches 1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt - 16'd1;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (accept) begin
          if (kp.bounce_en && BOUNCE_ON) begin
            state_nxt = P_BOUNCE;
            cnt_nxt   = BOUNCE_LEN;
          end else begin
            state_nxt = HOLD;
            cnt_nxt   = hold_sel;
          end
        end
      end
      P_BOUNCE: begin
        if (cnt <= 16'd1) begin
          state_nxt = HOLD;
          cnt_nxt   = hold_l;
        end
      end
      HOLD: begin
        if (cnt <= 16'd1) begin
          if (bounce_l && BOUNCE_ON) begin
            state_nxt = R_BOUNCE;
            cnt_nxt   = BOUNCE_LEN;
          end else if (GAP_ON) begin
            state_nxt = GAP;
            cnt_nxt   = GAP_LEN;
          end else begin
            state_nxt = DONE;
            cnt_nxt   = '0;
          end
        end
      end
      R_BOUNCE, GAP: begin
        if (cnt <= 16'd1) begin
          if (state == R_BOUNCE && GAP_ON) begin
            state_nxt = GAP;
            cnt_nxt   = GAP_LEN;
          end else begin
            state_nxt = DONE;
            cnt_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (kp.abort && state != IDLE && state != DONE) begin
      state_nxt = GAP_ON ? GAP : DONE;
      cnt_nxt   = GAP_ON ? GAP_LEN : 16'd0;
    end
  end

  // Contact state is registered against the LFSR value it will sit beside.
  always_comb begin
    key_active_nxt = 1'b0;
    case (state_nxt)
      P_BOUNCE, R_BOUNCE: key_active_nxt = lfsr_nxt[0];
      HOLD:               key_active_nxt = 1'b1;
      default:            key_active_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      lfsr       <= LFSR_SEED;
      key_active <= 1'b0;
      hold_l     <= '0;
      bounce_l   <= 1'b0;
      k_col      <= '0;
      k_row      <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      lfsr       <= lfsr_nxt;
      key_active <= key_active_nxt;
      if (accept) begin
        hold_l   <= hold_sel;
        bounce_l <= kp.bounce_en;
        k_col    <= map_col;
        k_row    <= map_row;
      end
    end
  end

  // Physical matrix: any Col pattern with the key's column low closes the path.
  always_comb begin
    row_drv = 4'b1111;
    if (key_active && !kp.Col[k_col]) row_drv[k_row] = 1'b0;
  end

  assign kp.Row        = row_drv;
  assign kp.key_active = key_active;
  assign kp.ready      = (state == IDLE);
  assign kp.done       = (state == DONE);
endmodule
